// File: rtl/dispatcher_pkg.sv
// Shared helpers for the dispatcher.
// Contents:
//   popcount - number of set bits in a vector of up to 64 bits.
package dispatcher_pkg;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dispatcher_priority_encoder.sv
// Priority encoder.
// Picks the highest-priority set bit of i_in.
// LSB_HIGH_PRIORITY=1 makes bit 0 the highest priority; 0 makes bit WIDTH-1 the highest.
// Ports:
//   i_in      [WIDTH-1:0]  candidate bits
//   o_valid                any bit set
//   o_index   [IdxW-1:0]   binary index of the winner (0 when none)
//   o_onehot  [WIDTH-1:0]  one-hot winner (0 when none)
module priority_encoder #(
  parameter int unsigned WIDTH             = 4,
  parameter bit          LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned IdxW             = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_in,
  output logic             o_valid,
  output logic [IdxW-1:0]  o_index,
  output logic [WIDTH-1:0] o_onehot
);

  always_comb begin
    o_valid  = |i_in;
    o_index  = '0;
    o_onehot = '0;
    // Scan from lowest to highest priority; the last hit wins.
    if (LSB_HIGH_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_in[i]) o_index = IdxW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_in[i]) o_index = IdxW'(i);
      end
    end
    if (o_valid) o_onehot[o_index] = 1'b1;
  end

endmodule

// File: rtl/dispatcher.sv
// Single-requester, multi-server job dispatcher.
// Tracks per-server busy state from grant to done and hands each accepted job to one idle,
// enabled server using fixed or round-robin priority.
// Optional feature (macro DISPATCHER_ERR_EN): sticky o_err flag set by a done pulse
// on an idle server; without the macro such pulses are silently ignored.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req_valid / o_req_ready   upstream job handshake
//   i_enable   [PORTS-1:0]      server online mask
//   i_done     [PORTS-1:0]      per-server completion pulses
//   o_grant    [PORTS-1:0]      registered one-hot grant
//   o_grant_valid               registered, one cycle per accepted job
//   o_grant_encoded [IdxW-1:0]  binary index of o_grant
//   o_busy     [PORTS-1:0]      registered busy flags
//   o_busy_count [CntW-1:0]     registered popcount of o_busy
//   o_err                       (DISPATCHER_ERR_EN only) sticky idle-done error
module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int unsigned PORTS                 = 4,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b1,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned IdxW                 = $clog2(PORTS),
  localparam int unsigned CntW                 = $clog2(PORTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [PORTS-1:0] i_enable,
  input  logic [PORTS-1:0] i_done,
`ifdef DISPATCHER_ERR_EN
  output logic             o_err,
`endif
  output logic [PORTS-1:0] o_grant,
  output logic             o_grant_valid,
  output logic [IdxW-1:0]  o_grant_encoded,
  output logic [PORTS-1:0] o_busy,
  output logic [CntW-1:0]  o_busy_count
);

  logic [PORTS-1:0] r_busy, r_mask, r_grant;
  logic             r_grant_valid;
  logic [IdxW-1:0]  r_grant_encoded;
  logic [CntW-1:0]  r_busy_count;

  logic [PORTS-1:0] w_free, w_free_masked;
  logic             w_free_valid, w_masked_valid;
  logic [IdxW-1:0]  w_free_idx, w_masked_idx, w_sel_idx;
  logic [PORTS-1:0] w_free_oh, w_masked_oh, w_sel_oh;
  logic             w_accept;
  logic [PORTS-1:0] w_busy_d, w_mask_d, w_grant_d;
  logic [PORTS-1:0] w_ones;

  assign w_free        = ~r_busy & i_enable;
  assign w_free_masked = w_free & r_mask;
  // Gated by rst_n so upstream never sees ready while the block is held in reset.
  assign o_req_ready   = rst_n & (|w_free);
  assign w_accept      = i_req_valid & o_req_ready;
  assign w_ones        = '1;

  priority_encoder #(
    .WIDTH            (PORTS),
    .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)
  ) u_enc_free (
    .i_in    (w_free),
    .o_valid (w_free_valid),
    .o_index (w_free_idx),
    .o_onehot(w_free_oh)
  );

  priority_encoder #(
    .WIDTH            (PORTS),
    .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)
  ) u_enc_masked (
    .i_in    (w_free_masked),
    .o_valid (w_masked_valid),
    .o_index (w_masked_idx),
    .o_onehot(w_masked_oh)
  );

  always_comb begin
    w_sel_idx = w_free_idx;
    w_sel_oh  = w_free_oh;
    // Round-robin falls back to the unmasked winner once the mask has wrapped.
    if (ARB_TYPE_ROUND_ROBIN && w_masked_valid) begin
      w_sel_idx = w_masked_idx;
      w_sel_oh  = w_masked_oh;
    end
  end

  always_comb begin
    w_grant_d = w_accept ? w_sel_oh : '0;
    // The selected port is never busy, so a done on it cannot race the set.
    w_busy_d  = (r_busy & ~i_done) | w_grant_d;
    w_mask_d  = r_mask;
    if (ARB_TYPE_ROUND_ROBIN && w_accept) begin
      if (ARB_LSB_HIGH_PRIORITY) w_mask_d = w_ones << (int'(w_sel_idx) + 1);
      else                       w_mask_d = w_ones >> (int'(PORTS) - int'(w_sel_idx));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy          <= '0;
      r_mask          <= '0;
      r_grant         <= '0;
      r_grant_valid   <= 1'b0;
      r_grant_encoded <= '0;
      r_busy_count    <= '0;
    end else begin
      r_busy          <= w_busy_d;
      r_mask          <= w_mask_d;
      r_grant         <= w_grant_d;
      r_grant_valid   <= w_accept;
      r_grant_encoded <= w_accept ? w_sel_idx : '0;
      r_busy_count    <= CntW'(popcount(64'(w_busy_d)));
    end
  end

`ifdef DISPATCHER_ERR_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err | (|(i_done & ~r_busy));
  end
  assign o_err = r_err;
`endif

  assign o_grant         = r_grant;
  assign o_grant_valid   = r_grant_valid;
  assign o_grant_encoded = r_grant_encoded;
  assign o_busy          = r_busy;
  assign o_busy_count    = r_busy_count;

endmodule
